cubic_tap_sequencer: RTL and testbench
======================================

# cubic_tap_sequencer

Upstream feeder for `Cubic_engine` in the bicubic scaling datapath. For one output row it steps a Q8.8 source position across `dst_w` destination pixels. Each 5-cycle group it does three things:
- generates the packed fraction powers x, x², x³ (Q0.8) for `X_in`;
- issues the four clamped tap addresses P(-1), P(0), P(1), P(2) to the synchronous image memory;
- drives the shared 3-bit `cycle_cnt` phase counter that the engine consumes.

## Interface
- `SRC_W_BITS`, 7: width of `src_w`; max source width 64.
- `DST_W_BITS`, 8: width of `dst_w`; max destination width 128.
- `ADDR_BITS`, 14: image memory address width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to process one row; sampled only in IDLE.
- `src_w` in SRC_W_BITS: source row width in pixels; ≥1.
- `dst_w` in DST_W_BITS: number of output pixels; ≥1.
- `step` in 16: position increment per output pixel, Q8.8.
- `row_base` in ADDR_BITS: address of source pixel (row, col 0).
- `img_addr` out ADDR_BITS: memory read address; data returns next cycle.
- `img_di` in 8: memory read data.
- `P_out` out 8: equals `img_di`, combinational passthrough to engine `P_in`.
- `X_out` out 24: engine `X_in`, packed as {x, x², x³}. [23:16]=x, [15:8]=x², [7:0]=x³.
- `cycle_cnt` out 3: phase 0..4 to engine.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse after the last group.

## Operation
- FSM states:
  - IDLE: `start`=1 → RUN, with phase=0, dst index=0, pos=0.
  - RUN: phase steps 0→1→2→3→4→0. At phase 4: if dst index = dst_w-1 → DONE; else dst index +1, pos += step, and the next group starts.
  - DONE: one cycle, `done`=1, then → IDLE.
- `start` is ignored outside IDLE.
- Position fields: pos is 16-bit Q8.8, integer i = pos[15:8], fraction f = pos[7:0]. pos wraps modulo 2^16 with no saturation.
- Powers use truncation throughout:
  - x = f
  - x² = (f·f)>>8
  - x³ = (x²·f)>>8, using the truncated x².
- `X_out` is registered. It loads on entry to phase 0 of each group (from the new pos) and holds for all 5 phases.
- Tap column for phase k, k=0..3: c = i + k − 1, clamped to [0, src_w−1]. Compute signed, at least 10 bits wide. `img_addr` = row_base + c.
- Phase 4: `img_addr` holds the phase-3 value.
- The engine therefore sees P(-1) during phase 1, P(0) at 2, P(1) at 3, P(2) at 4.
- Reset values: `img_addr`=0, `X_out`=0, `cycle_cnt`=0, `busy`=0, `done`=0, state IDLE, pos=0.
- `rst` low mid-row aborts at the next edge: no `done`, and all outputs return to reset values.

## Timing
- `start` accepted at edge T. At T+1: RUN, `cycle_cnt`=0, `X_out` valid for group 0, `img_addr`=tap −1.
- Each group lasts exactly 5 cycles, with no bubbles between groups.
- Row latency from start to the `done` pulse: 5·dst_w + 1 cycles.
- `cycle_cnt` is 0 in IDLE/DONE. `busy`=1 only in RUN.
- `start` in the DONE cycle is ignored. Back-to-back rows start from IDLE, so the gap is at least 1 cycle.
- `src_w`, `dst_w`, `step`, `row_base` are sampled at start acceptance and held internally; input changes during RUN have no effect.

## Structure
- Shared package `bicubic_pkg` holds:
  - phase constants PH_TM1=0 … PH_OUT=4;
  - FSM state enum;
  - Q-format widths (FRAC_BITS=8, POS_BITS=16).
- Sub-module `cubic_power_gen`: combinational f → {x, x², x³}, two 8×8 multipliers. Unit-testable standalone.
- Remainder lives in the sequencer:
  - FSM;
  - phase and dst counters;
  - pos accumulator;
  - clamp/address adder.

## Test plan
- Powers: src_w=8, dst_w=3, step=0x00AB, row_base=0 → `X_out` per group = 0x000000, 0xAB724C, 0x561C09; `done` at 16 cycles after acceptance.
- Left/right clamp: src_w=4, step=0x0100, dst_w=4 → group 0 addrs 0,0,1,2; group 3 addrs 2,3,3,3; `X_out`=0 throughout.
- Row base + phase alignment: row_base=0x0140, memory returns addr[7:0] → `P_out` in phases 1..4 of group 1 (i=1) = 0x40,0x41,0x42,0x43; `cycle_cnt` sequence 0,1,2,3,4 repeating.
- Reset mid-row: rst low during group 2 phase 3 → next edge all outputs 0, IDLE, no `done`. A new start then restarts from pos=0.
- `start` ignored: pulse `start` during RUN and during DONE → no restart; group count = dst_w exactly.
- Single pixel: dst_w=1, src_w=1, step=0x0180 → one group, all four taps addr row_base, `X_out`=0, `done` at T+6.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared definitions for the bicubic scaling datapath: Q-format widths,
// engine phase numbering and the tap sequencer state encoding.
package bicubic_pkg;

    localparam int FRAC_BITS = 8;
    localparam int POS_BITS  = 16;
    // Signed column width: holds i + k - 1 for i in 0..255, k in 0..3
    localparam int COL_BITS  = 10;

    localparam logic [2:0] PH_TM1 = 3'd0;
    localparam logic [2:0] PH_T0  = 3'd1;
    localparam logic [2:0] PH_TP1 = 3'd2;
    localparam logic [2:0] PH_TP2 = 3'd3;
    localparam logic [2:0] PH_OUT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cubic_power_gen.sv
// Combinational Q0.8 fraction powers {x, x^2, x^3}, truncating after each
// multiply so x^3 is built from the already-truncated x^2.
module cubic_power_gen
    import bicubic_pkg::*;
(
    input  logic [FRAC_BITS-1:0]   f_in,
    output logic [3*FRAC_BITS-1:0] x_pack
);

    logic [2*FRAC_BITS-1:0] f_ext;
    logic [2*FRAC_BITS-1:0] sq_full;
    logic [2*FRAC_BITS-1:0] cube_full;
    logic [FRAC_BITS-1:0]   sq;
    logic                   unused_low;

    assign f_ext     = {{FRAC_BITS{1'b0}}, f_in};
    assign sq_full   = f_ext * f_ext;
    assign sq        = sq_full[2*FRAC_BITS-1:FRAC_BITS];
    assign cube_full = {{FRAC_BITS{1'b0}}, sq} * f_ext;
    assign x_pack    = {f_in, sq, cube_full[2*FRAC_BITS-1:FRAC_BITS]};

    assign unused_low = ^{sq_full[FRAC_BITS-1:0], cube_full[FRAC_BITS-1:0]};

endmodule

// File: rtl/cubic_tap_sequencer.sv
// Steps a Q8.8 source position across one output row, issuing four clamped
// tap reads and the fraction powers per 5-cycle engine group.
module cubic_tap_sequencer
    import bicubic_pkg::*;
#(
    parameter int SRC_W_BITS = 7,
    parameter int DST_W_BITS = 8,
    parameter int ADDR_BITS  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SRC_W_BITS-1:0] src_w,
    input  logic [DST_W_BITS-1:0] dst_w,
    input  logic [15:0]           step,
    input  logic [ADDR_BITS-1:0]  row_base,
    output logic [ADDR_BITS-1:0]  img_addr,
    input  logic [7:0]            img_di,
    output logic [7:0]            P_out,
    output logic [23:0]           X_out,
    output logic [2:0]            cycle_cnt,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic [DST_W_BITS-1:0] dst_idx_q, dst_idx_d;
    logic [DST_W_BITS-1:0] dst_w_q, dst_w_d;
    logic [SRC_W_BITS-1:0] src_w_q, src_w_d;
    logic [POS_BITS-1:0]   pos_q, pos_d;
    logic [POS_BITS-1:0]   step_q, step_d;
    logic [ADDR_BITS-1:0]  row_base_q, row_base_d;
    logic [ADDR_BITS-1:0]  img_addr_q, img_addr_d;
    logic [23:0]           x_out_q, x_out_d;

    // Single clamp/adder shared by all address updates; operands are muxed in
    logic [POS_BITS-1:0]        tap_pos;
    logic [1:0]                 tap_k;
    logic [SRC_W_BITS-1:0]      tap_src_w;
    logic [ADDR_BITS-1:0]       tap_base;
    logic [ADDR_BITS-1:0]       tap_addr;
    logic                       addr_load;
    logic                       x_load;
    logic [23:0]                pow_w;
    logic signed [COL_BITS-1:0] col_raw, col_max, col_clamped;

    cubic_power_gen u_power_gen (
        .f_in   (tap_pos[FRAC_BITS-1:0]),
        .x_pack (pow_w)
    );

    always_comb begin
        col_raw = $signed({{(COL_BITS-8){1'b0}}, tap_pos[POS_BITS-1:FRAC_BITS]})
                + $signed({{(COL_BITS-2){1'b0}}, tap_k}) - COL_BITS'(1);
        col_max = {{(COL_BITS-SRC_W_BITS){1'b0}}, tap_src_w} - COL_BITS'(1);
        if (col_raw[COL_BITS-1]) begin
            col_clamped = '0;
        end else if (col_raw > col_max) begin
            col_clamped = col_max;
        end else begin
            col_clamped = col_raw;
        end
        tap_addr = tap_base + {{(ADDR_BITS-COL_BITS){1'b0}}, col_clamped};
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dst_idx_d  = dst_idx_q;
        dst_w_d    = dst_w_q;
        src_w_d    = src_w_q;
        pos_d      = pos_q;
        step_d     = step_q;
        row_base_d = row_base_q;
        tap_pos    = pos_q;
        tap_k      = phase_q[1:0] + 2'd1;
        tap_src_w  = src_w_q;
        tap_base   = row_base_q;
        addr_load  = 1'b0;
        x_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    phase_d    = PH_TM1;
                    dst_idx_d  = '0;
                    pos_d      = '0;
                    dst_w_d    = dst_w;
                    src_w_d    = src_w;
                    step_d     = step;
                    row_base_d = row_base;
                    // First group is driven straight from the live inputs
                    tap_pos    = '0;
                    tap_k      = 2'd0;
                    tap_src_w  = src_w;
                    tap_base   = row_base;
                    addr_load  = 1'b1;
                    x_load     = 1'b1;
                end
            end
            ST_RUN: begin
                if (phase_q == PH_OUT) begin
                    if (dst_idx_q == dst_w_q - DST_W_BITS'(1)) begin
                        state_d = ST_DONE;
                        phase_d = PH_TM1;
                    end else begin
                        dst_idx_d = dst_idx_q + DST_W_BITS'(1);
                        pos_d     = pos_q + step_q;
                        phase_d   = PH_TM1;
                        tap_pos   = pos_q + step_q;
                        tap_k     = 2'd0;
                        addr_load = 1'b1;
                        x_load    = 1'b1;
                    end
                end else begin
                    phase_d   = phase_q + 3'd1;
                    // Phase 4 keeps the last tap address on the bus
                    addr_load = (phase_q != PH_TP2);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        img_addr_d = addr_load ? tap_addr : img_addr_q;
        x_out_d    = x_load ? pow_w : x_out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_TM1;
            dst_idx_q  <= '0;
            dst_w_q    <= '0;
            src_w_q    <= '0;
            pos_q      <= '0;
            step_q     <= '0;
            row_base_q <= '0;
            img_addr_q <= '0;
            x_out_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            dst_idx_q  <= dst_idx_d;
            dst_w_q    <= dst_w_d;
            src_w_q    <= src_w_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            row_base_q <= row_base_d;
            img_addr_q <= img_addr_d;
            x_out_q    <= x_out_d;
        end
    end

    assign img_addr  = img_addr_q;
    assign X_out     = x_out_q;
    assign cycle_cnt = phase_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign P_out     = img_di;

endmodule

// File: tb/tb_cubic_tap_sequencer.sv
// Randomised row bench for cubic_tap_sequencer against a cycle-indexed
// arithmetic reference of positions, clamped taps and truncated powers.
module tb_cubic_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  src_w = '0;
    logic [7:0]  dst_w = '0;
    logic [15:0] step = '0;
    logic [13:0] row_base = '0;
    logic [13:0] img_addr;
    logic [7:0]  img_di = '0;
    logic [7:0]  P_out;
    logic [23:0] X_out;
    logic [2:0]  cycle_cnt;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    cubic_tap_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_w     (src_w),
        .dst_w     (dst_w),
        .step      (step),
        .row_base  (row_base),
        .img_addr  (img_addr),
        .img_di    (img_di),
        .P_out     (P_out),
        .X_out     (X_out),
        .cycle_cnt (cycle_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous image memory whose content is the low address byte
    always @(posedge clk) img_di <= img_addr[7:0];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_pow(input int f);
        int x2;
        int x3;
        x2 = (f * f) / 256;
        x3 = (x2 * f) / 256;
        return (f << 16) | (x2 << 8) | x3;
    endfunction

    function automatic int ref_addr(input int rb, input int i, input int k, input int sw);
        int c;
        c = i + k - 1;
        if (c < 0) c = 0;
        if (c > sw - 1) c = sw - 1;
        return (rb + c) % 16384;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, int'(img_addr), 0);
        check({tag, "_xout"}, int'(X_out), 0);
        check({tag, "_cyc"}, int'(cycle_cnt), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Runs one row starting from IDLE; abort_n > 0 pulls reset after that cycle
    task automatic run_row(input int sw, input int dw, input int st, input int rb,
                           input int abort_n);
        int g, p, pos, i, k;
        $display("row src_w=%0d dst_w=%0d step=0x%04h base=0x%04h abort=%0d",
                 sw, dw, st, rb, abort_n);
        src_w    = 7'(sw);
        dst_w    = 8'(dw);
        step     = 16'(st);
        row_base = 14'(rb);
        start    = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 5 * dw + 1; n++) begin
            // Noise on every input; none of it may affect the row in flight
            start    = 1'($urandom);
            src_w    = 7'($urandom);
            dst_w    = 8'($urandom);
            step     = 16'($urandom);
            row_base = 14'($urandom);
            @(negedge clk);
            if (n <= 5 * dw) begin
                g   = (n - 1) / 5;
                p   = (n - 1) % 5;
                pos = (g * st) % 65536;
                i   = pos / 256;
                k   = (p > 3) ? 3 : p;
                check("cyc", int'(cycle_cnt), p);
                check("busy", int'(busy), 1);
                check("done", int'(done), 0);
                check("xout", int'(X_out), ref_pow(pos % 256));
                check("addr", int'(img_addr), ref_addr(rb, i, k, sw));
                if (p >= 1)
                    check("pout", int'(P_out), ref_addr(rb, i, p - 1, sw) % 256);
            end else begin
                check("done_cyc", int'(cycle_cnt), 0);
                check("done_busy", int'(busy), 0);
                check("done_pulse", int'(done), 1);
            end
            if (n == abort_n) begin
                rst = 1'b0;
                @(posedge clk); #1;
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                check_zero("abort");
                @(posedge clk); #1;
                @(negedge clk);
                check("abort_nodone", int'(done), 0);
                check("abort_idle", int'(busy), 0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        check("idle_done", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_cyc", int'(cycle_cnt), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int sw, dw, st, rb;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_row(8, 3, 'h00AB, 0, 0);
        run_row(4, 4, 'h0100, 0, 0);
        run_row(8, 4, 'h0100, 'h0140, 0);
        run_row(1, 1, 'h0180, 'h0055, 0);
        run_row(8, 5, 'h00C0, 'h0020, 14);
        run_row(8, 5, 'h00C0, 'h0020, 0);
        run_row(64, 128, 'h0F37, 'h3FF0, 0);

        for (int t = 0; t < 30; t++) begin
            sw = $urandom_range(1, 64);
            dw = $urandom_range(1, 12);
            st = (t % 2 == 0) ? $urandom_range(0, 'h0500) : $urandom_range(0, 'hFFFF);
            rb = $urandom_range(0, 'h3FFF);
            run_row(sw, dw, st, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
